// File: rtl/sw_wavefront_sched.sv
`default_nettype none
// ============================================================================
// Module  : sw_wavefront_sched
// Purpose : Strip-by-strip query load and anti-diagonal reference sweep
//           sequencer for a linear Smith-Waterman PE array.
//           Optional macro SW_SCHED_PERF_EN adds cycle/stall counters.
// Revision: 1.0
// ============================================================================
module sw_wavefront_sched #(
  parameter int NPE             = 16,
  parameter int RLEN            = 64,
  parameter int QLEN            = 48,
  parameter int PE_LAT          = 2,
  parameter int WIDTH_POS_REF   = 7,
  parameter int WIDTH_POS_QUERY = 6,
  parameter int PE_IDX_W        = 4,
  parameter int STRIP_W         = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       ready,
  output logic                       busy,
  output logic                       done,
  input  logic                       stall,
  output logic [WIDTH_POS_QUERY-1:0] q_rd_addr,
  output logic                       q_load_en,
  output logic [PE_IDX_W-1:0]        q_load_sel,
  output logic                       ref_rd_en,
  output logic [WIDTH_POS_REF-1:0]   ref_rd_addr,
  output logic [NPE-1:0]             pe_en,
  output logic [STRIP_W-1:0]         strip_idx,
  output logic                       strip_first,
  output logic                       bnd_rd_en,
  output logic [WIDTH_POS_REF-1:0]   bnd_rd_addr,
  output logic                       bnd_wr_en,
  output logic [WIDTH_POS_REF-1:0]   bnd_wr_addr
`ifdef SW_SCHED_PERF_EN
  ,
  output logic [15:0]                cyc_cnt,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int                 NSTRIP       = QLEN / NPE;
  localparam logic [7:0]         T_QLOAD_LAST = 8'(NPE - 1);
  localparam logic [7:0]         T_SWEEP_LAST = 8'(RLEN + NPE - 2);
  localparam logic [7:0]         T_FLUSH_LAST = 8'(PE_LAT - 1);
  localparam logic [7:0]         T_REF_END    = 8'(RLEN);
  localparam logic [7:0]         T_WR_FIRST   = 8'(NPE - 1);
  localparam logic [STRIP_W-1:0] S_LAST       = STRIP_W'(NSTRIP - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_QLOAD = 3'd1,
    ST_SWEEP = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         t_q, t_d;
  logic [STRIP_W-1:0] s_q, s_d;

  logic w_in_qload;
  logic w_in_sweep;
  logic w_busy;
  logic w_qload_go;
  logic w_sweep_go;
  logic w_ref_win;
  logic w_wr_win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    s_d     = s_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_QLOAD;
          t_d     = '0;
          s_d     = '0;
        end
      end
      ST_QLOAD: begin
        if (!stall) begin
          if (t_q == T_QLOAD_LAST) begin
            t_d     = '0;
            state_d = ST_SWEEP;
          end else begin
            t_d = t_q + 8'd1;
          end
        end
      end
      ST_SWEEP: begin
        if (!stall) begin
          if (t_q == T_SWEEP_LAST) begin
            t_d = '0;
            if (s_q == S_LAST) begin
              state_d = ST_FLUSH;
            end else begin
              s_d     = s_q + 1'b1;
              state_d = ST_QLOAD;
            end
          end else begin
            t_d = t_q + 8'd1;
          end
        end
      end
      ST_FLUSH: begin
        // Lets the PE pipeline drain before the max-tracker sees done.
        if (t_q == T_FLUSH_LAST) begin
          t_d     = '0;
          state_d = ST_DONE;
        end else begin
          t_d = t_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        t_d     = '0;
        s_d     = '0;
      end
      default: begin
        state_d = ST_IDLE;
        t_d     = '0;
        s_d     = '0;
      end
    endcase
  end

  assign w_in_qload = (state_q == ST_QLOAD);
  assign w_in_sweep = (state_q == ST_SWEEP);
  assign w_busy     = w_in_qload || w_in_sweep || (state_q == ST_FLUSH);
  assign w_qload_go = w_in_qload && !stall;
  assign w_sweep_go = w_in_sweep && !stall;
  assign w_ref_win  = (t_q < T_REF_END);
  assign w_wr_win   = (t_q >= T_WR_FIRST);

  assign ready = (state_q == ST_IDLE);
  assign busy  = w_busy;
  assign done  = (state_q == ST_DONE);

  assign q_load_en  = w_qload_go;
  assign q_load_sel = w_in_qload ? PE_IDX_W'(t_q) : '0;
  assign q_rd_addr  = w_in_qload ? WIDTH_POS_QUERY'(32'(s_q) * NPE + 32'(t_q)) : '0;

  assign ref_rd_en   = w_sweep_go && w_ref_win;
  assign ref_rd_addr = w_in_sweep ? WIDTH_POS_REF'(t_q) : '0;

  assign strip_idx   = w_busy ? s_q : '0;
  assign strip_first = w_busy && (s_q == '0);

  // Strip 0 has no previous strip to read from; the last strip has no successor.
  assign bnd_rd_en   = w_sweep_go && w_ref_win && (s_q != '0);
  assign bnd_rd_addr = w_in_sweep ? WIDTH_POS_REF'(t_q) : '0;
  assign bnd_wr_en   = w_sweep_go && w_wr_win && (s_q != S_LAST);
  assign bnd_wr_addr = (w_in_sweep && w_wr_win) ? WIDTH_POS_REF'(t_q - T_WR_FIRST) : '0;

  for (genvar k = 0; k < NPE; k++) begin : g_pe_en
    localparam logic [8:0] C_LO = 9'(k);
    localparam logic [8:0] C_HI = 9'(k + RLEN);
    assign pe_en[k] = w_sweep_go && ({1'b0, t_q} >= C_LO) && ({1'b0, t_q} < C_HI);
  end

`ifdef SW_SCHED_PERF_EN
  logic [15:0] cyc_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (ready && start) begin
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (w_busy) begin
      if (cyc_cnt_q != 16'hFFFF) begin
        cyc_cnt_q <= cyc_cnt_q + 16'd1;
      end
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign cyc_cnt   = cyc_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sw_wavefront_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_sw_wavefront_sched
// Purpose : Randomized self-checking bench for sw_wavefront_sched against a
//           progress-count reference model. Honors SW_SCHED_PERF_EN.
// Revision: 1.0
// ============================================================================
module tb_sw_wavefront_sched;

  localparam int NPE       = 16;
  localparam int RLEN      = 64;
  localparam int QLEN      = 48;
  localparam int PE_LAT    = 2;
  localparam int NSTRIP    = QLEN / NPE;
  localparam int SW_LEN    = RLEN + NPE - 1;
  localparam int STRIP_LEN = NPE + SW_LEN;
  localparam int WORK      = NSTRIP * STRIP_LEN;
  localparam int DONE_P    = WORK + PE_LAT;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            stall;
  logic            ready, busy, done;
  logic [5:0]      q_rd_addr;
  logic            q_load_en;
  logic [3:0]      q_load_sel;
  logic            ref_rd_en;
  logic [6:0]      ref_rd_addr;
  logic [NPE-1:0]  pe_en;
  logic [1:0]      strip_idx;
  logic            strip_first;
  logic            bnd_rd_en;
  logic [6:0]      bnd_rd_addr;
  logic            bnd_wr_en;
  logic [6:0]      bnd_wr_addr;
`ifdef SW_SCHED_PERF_EN
  logic [15:0]     cyc_cnt;
  logic [15:0]     stall_cnt;
`endif

  always #5 clk = ~clk;

  sw_wavefront_sched dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .stall       (stall),
    .q_rd_addr   (q_rd_addr),
    .q_load_en   (q_load_en),
    .q_load_sel  (q_load_sel),
    .ref_rd_en   (ref_rd_en),
    .ref_rd_addr (ref_rd_addr),
    .pe_en       (pe_en),
    .strip_idx   (strip_idx),
    .strip_first (strip_first),
    .bnd_rd_en   (bnd_rd_en),
    .bnd_rd_addr (bnd_rd_addr),
    .bnd_wr_en   (bnd_wr_en),
    .bnd_wr_addr (bnd_wr_addr)
`ifdef SW_SCHED_PERF_EN
    ,
    .cyc_cnt     (cyc_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: a job is a count of productive cycles m_p.
  // Each strip is NPE load steps then RLEN+NPE-1 sweep steps; then PE_LAT flush, then done.
  bit m_act;
  int m_p;
  int m_cyc;
  int m_stl;

  logic           e_ready, e_busy, e_done;
  logic           e_qen;
  logic [3:0]     e_qsel;
  logic [5:0]     e_qaddr;
  logic           e_ren;
  logic [6:0]     e_raddr;
  logic [NPE-1:0] e_pe;
  logic [1:0]     e_strip;
  logic           e_first;
  logic           e_brd_en, e_bwr_en;
  logic [6:0]     e_brd_addr, e_bwr_addr;

  int a_cyc, a_busy, a_done, a_done_at, a_wr, a_rd, a_exp_stall;

  task automatic model_reset();
    m_act = 1'b0;
    m_p   = 0;
    m_cyc = 0;
    m_stl = 0;
  endtask

  task automatic compute_exp(input bit sl);
    int  strip, w, t;
    bit  go;
    e_ready = !m_act; e_busy = 1'b0; e_done = 1'b0;
    e_qen = 1'b0; e_qsel = '0; e_qaddr = '0;
    e_ren = 1'b0; e_raddr = '0; e_pe = '0;
    e_strip = '0; e_first = 1'b0;
    e_brd_en = 1'b0; e_brd_addr = '0; e_bwr_en = 1'b0; e_bwr_addr = '0;
    if (m_act) begin
      if (m_p < WORK) begin
        strip   = m_p / STRIP_LEN;
        w       = m_p % STRIP_LEN;
        go      = !sl;
        e_busy  = 1'b1;
        e_strip = 2'(strip);
        e_first = (strip == 0);
        if (w < NPE) begin
          t       = w;
          e_qen   = go;
          e_qsel  = 4'(t);
          e_qaddr = 6'(strip * NPE + t);
        end else begin
          t          = w - NPE;
          e_raddr    = 7'(t);
          e_ren      = go && (t < RLEN);
          e_brd_addr = 7'(t);
          e_brd_en   = go && (t < RLEN) && (strip != 0);
          e_bwr_addr = (t >= NPE - 1) ? 7'(t - (NPE - 1)) : 7'd0;
          e_bwr_en   = go && (t >= NPE - 1) && (strip != NSTRIP - 1);
          for (int k = 0; k < NPE; k++) e_pe[k] = go && (t >= k) && (t < k + RLEN);
        end
      end else if (m_p < DONE_P) begin
        e_busy  = 1'b1;
        e_strip = 2'(NSTRIP - 1);
      end else begin
        e_done = 1'b1;
      end
    end
  endtask

  task automatic model_edge(input bit st, input bit sl);
    if (!m_act) begin
      if (st) begin
        m_act = 1'b1;
        m_p   = 0;
        m_cyc = 0;
        m_stl = 0;
      end
    end else begin
      if (m_p < DONE_P) begin
        if (m_cyc < 65535) m_cyc++;
        if (sl && m_stl < 65535) m_stl++;
      end
      if (m_p < WORK) begin
        if (!sl) m_p++;
      end else if (m_p < DONE_P) begin
        m_p++;
      end else begin
        m_act = 1'b0;
      end
    end
  endtask

  task automatic compare_all(input bit sl);
    compute_exp(sl);
    check_eq("ctrl",   64'({ready, busy, done}), 64'({e_ready, e_busy, e_done}));
    check_eq("qload",  64'({q_load_en, q_load_sel, q_rd_addr}), 64'({e_qen, e_qsel, e_qaddr}));
    check_eq("ref",    64'({ref_rd_en, ref_rd_addr}), 64'({e_ren, e_raddr}));
    check_eq("pe_en",  64'(pe_en), 64'(e_pe));
    check_eq("strip",  64'({strip_idx, strip_first}), 64'({e_strip, e_first}));
    check_eq("bnd_rd", 64'({bnd_rd_en, bnd_rd_addr}), 64'({e_brd_en, e_brd_addr}));
    check_eq("bnd_wr", 64'({bnd_wr_en, bnd_wr_addr}), 64'({e_bwr_en, e_bwr_addr}));
`ifdef SW_SCHED_PERF_EN
    check_eq("cyc_cnt",   64'(cyc_cnt),   64'(m_cyc));
    check_eq("stall_cnt", 64'(stall_cnt), 64'(m_stl));
`endif
  endtask

  // Drive inputs just after a rising edge, check mid-cycle, then advance the model on the next edge.
  task automatic cycle(input bit st, input bit sl);
    start = st;
    stall = sl;
    #1;
    compare_all(sl);
    if (m_act && !sl && m_p >= NPE && m_p < STRIP_LEN) begin
      case (m_p - NPE)
        0:  check_eq("pe_t0",  64'(pe_en), 64'h0001);
        15: check_eq("pe_t15", 64'(pe_en), 64'hFFFF);
        63: check_eq("pe_t63", 64'(pe_en), 64'hFFFF);
        64: check_eq("pe_t64", 64'(pe_en), 64'hFFFE);
        78: check_eq("pe_t78", 64'(pe_en), 64'h8000);
        default: ;
      endcase
    end
    if (busy) a_busy++;
    if (done) begin
      a_done++;
      a_done_at = a_cyc;
    end
    if (bnd_wr_en) a_wr++;
    if (bnd_rd_en) a_rd++;
    if (m_act && m_p < WORK && sl) a_exp_stall++;
    a_cyc++;
    @(posedge clk);
    #1;
    model_edge(st, sl);
  endtask

  task automatic run_job(input int mode);
    int sl_given;
    bit st, sl;
    a_cyc = 0; a_busy = 0; a_done = 0; a_done_at = -1;
    a_wr = 0; a_rd = 0; a_exp_stall = 0;
    sl_given = 0;
    cycle(1'b1, 1'b0);
    while (m_act && a_cyc < 3000) begin
      st = ($urandom_range(0, 7) == 0);
      case (mode)
        1:       sl = (m_p == STRIP_LEN + NPE + 20) && (sl_given < 5);
        2:       sl = ($urandom_range(0, 3) == 0);
        default: sl = 1'b0;
      endcase
      if (sl) sl_given++;
      cycle(st, sl);
    end
    check_eq("job_end",    64'(m_act), 64'd0);
    check_eq("done_cnt",   64'(a_done), 64'd1);
    check_eq("done_lat",   64'(a_done_at), 64'(DONE_P + 1 + a_exp_stall));
    check_eq("busy_cyc",   64'(a_busy), 64'(DONE_P + a_exp_stall));
    check_eq("bnd_wr_cnt", 64'(a_wr), 64'd128);
    check_eq("bnd_rd_cnt", 64'(a_rd), 64'd128);
    if (mode == 0) check_eq("busy_nom", 64'(a_busy), 64'd287);
    if (mode == 1) begin
      check_eq("stall_len", 64'(a_exp_stall), 64'd5);
      check_eq("busy_stl",  64'(a_busy), 64'd292);
`ifdef SW_SCHED_PERF_EN
      check_eq("perf_stall", 64'(stall_cnt), 64'd5);
      check_eq("perf_cyc",   64'(cyc_cnt), 64'd292);
`endif
    end
  endtask

  task automatic reset_mid_job();
    cycle(1'b1, 1'b0);
    while (m_act && m_p != STRIP_LEN + 5 && a_cyc < 3000) cycle(1'b0, 1'b0);
    check_eq("rst_reach", 64'(m_p), 64'(STRIP_LEN + 5));
    reset = 1'b1;
    #1;
    model_reset();
    compare_all(1'b0);
    @(posedge clk);
    #1;
    compare_all(1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all(1'b0);
    reset = 1'b0;

    run_job(0);
    run_job(1);
    run_job(2);
    reset_mid_job();
    run_job(0);
    run_job(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
